// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer: FSM states, reset-cause
// codes and the counter-width helper.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } seq_state_t;

   localparam logic [1:0] CAUSE_EXT     = 2'd0;
   localparam logic [1:0] CAUSE_SOFT    = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   // Width needed to count up to the larger of two terminal values.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sequencer_timer.sv
// Saturating up-counter with synchronous clear/enable and a terminal-value
// compare; shared by the hold and inter-stage gap timers.
module sequencer_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] term,
   output logic [WIDTH-1:0] count,
   output logic             at_term
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign at_term = (count == term);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: holds every stage in reset, then releases them one at
// a time, waiting for each stage's ready before moving on.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned NUM_STAGES    = 3,
   parameter int unsigned MIN_ASSERT    = 32,
   parameter int unsigned STAGE_GAP     = 16,
   parameter int unsigned READY_TIMEOUT = 256
) (
   input  logic                  sys_clk,
   input  logic                  rst_sig,
   input  logic                  sw_rst_req,
   input  logic [NUM_STAGES-1:0] stage_ready,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  sys_ready,
   output logic [1:0]            rst_cause,
   output logic [2:0]            fault_stage
);

   localparam int unsigned    CNT_W     = cnt_width(MIN_ASSERT, READY_TIMEOUT);
   localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(MIN_ASSERT - 1);
   localparam logic [CNT_W-1:0] GAP_MIN   = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(READY_TIMEOUT - 1);
   localparam logic [2:0]       LAST      = 3'(NUM_STAGES - 1);

   seq_state_t       state;
   logic [2:0]       k;
   logic             hold_done;
   logic [CNT_W-1:0] hold_cnt_unused;
   logic [CNT_W-1:0] gap_count;
   logic             gap_expired;
   logic             ready_k;
   logic             advance;
   logic             drop;
   logic [2:0]       drop_idx;

   always_comb begin
      ready_k  = 1'b0;
      drop     = 1'b0;
      drop_idx = '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         if (k == 3'(i)) ready_k = stage_ready[i];
      end
      // Scan downwards so the lowest dropped stage is the one reported.
      for (int unsigned i = NUM_STAGES; i > 0; i--) begin
         if (!stage_ready[i-1]) begin
            drop     = 1'b1;
            drop_idx = 3'(i - 1);
         end
      end
   end

   assign advance = (state == RELEASE) && (gap_count >= GAP_MIN) && ready_k;

   sequencer_timer #(.WIDTH(CNT_W)) u_hold_timer (
      .clk     (sys_clk),
      .rst     (rst_sig),
      .clr     (state != HOLD),
      .en      (state == HOLD),
      .term    (HOLD_TERM),
      .count   (hold_cnt_unused),
      .at_term (hold_done)
   );

   // Restarting on each advance makes the count relative to the latest release.
   sequencer_timer #(.WIDTH(CNT_W)) u_gap_timer (
      .clk     (sys_clk),
      .rst     (rst_sig),
      .clr     ((state != RELEASE) || advance),
      .en      (state == RELEASE),
      .term    (GAP_TERM),
      .count   (gap_count),
      .at_term (gap_expired)
   );

   always_ff @(posedge sys_clk or posedge rst_sig) begin
      if (rst_sig) begin
         state       <= HOLD;
         k           <= '0;
         stage_rst   <= '1;
         sys_ready   <= 1'b0;
         rst_cause   <= CAUSE_EXT;
         fault_stage <= '0;
      end else begin
         unique case (state)
            HOLD: begin
               if (hold_done) begin
                  state     <= RELEASE;
                  k         <= '0;
                  stage_rst <= stage_rst << 1;
               end
            end
            RELEASE: begin
               if (sw_rst_req) begin
                  state     <= HOLD;
                  k         <= '0;
                  stage_rst <= '1;
                  rst_cause <= CAUSE_SOFT;
               end else if (advance) begin
                  if (k == LAST) begin
                     state     <= RUN;
                     sys_ready <= 1'b1;
                  end else begin
                     k         <= k + 3'd1;
                     stage_rst <= stage_rst << 1;
                  end
               end else if (gap_expired) begin
                  state       <= HOLD;
                  k           <= '0;
                  stage_rst   <= '1;
                  rst_cause   <= CAUSE_TIMEOUT;
                  fault_stage <= k;
               end
            end
            RUN: begin
               if (sw_rst_req) begin
                  state     <= HOLD;
                  k         <= '0;
                  stage_rst <= '1;
                  sys_ready <= 1'b0;
                  rst_cause <= CAUSE_SOFT;
               end else if (drop) begin
                  state       <= HOLD;
                  k           <= '0;
                  stage_rst   <= '1;
                  sys_ready   <= 1'b0;
                  rst_cause   <= CAUSE_TIMEOUT;
                  fault_stage <= drop_idx;
               end
            end
            default: begin
               state <= HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer: an event-time model predicts every
// output change, and a monitor matches observed changes against that queue.
module tb_reset_sequencer;
   import reset_sequencer_pkg::*;

   localparam int NS = 3;
   localparam int M  = 32;
   localparam int SG = 16;
   localparam int RT = 256;

   logic          sys_clk    = 1'b0;
   logic          rst_sig    = 1'b1;
   logic          sw_rst_req = 1'b0;
   logic [NS-1:0] stage_ready = '0;
   logic [NS-1:0] stage_rst;
   logic          sys_ready;
   logic [1:0]    rst_cause;
   logic [2:0]    fault_stage;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         edge_no;
      logic [2:0] rst_v;
      logic       rdy;
      logic [1:0] cause;
      logic [2:0] fault;
   } ev_t;

   ev_t plan[$];
   ev_t exp_q[$];

   int            rdy_at[NS];
   int            sw_a;
   int            sw_b;
   int            drop_at;
   logic [NS-1:0] drop_mask;
   logic [1:0]    m_cause;
   logic [2:0]    m_fault;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   reset_sequencer #(
      .NUM_STAGES    (NS),
      .MIN_ASSERT    (M),
      .STAGE_GAP     (SG),
      .READY_TIMEOUT (RT)
   ) dut (
      .sys_clk     (sys_clk),
      .rst_sig     (rst_sig),
      .sw_rst_req  (sw_rst_req),
      .stage_ready (stage_ready),
      .stage_rst   (stage_rst),
      .sys_ready   (sys_ready),
      .rst_cause   (rst_cause),
      .fault_stage (fault_stage)
   );

   function automatic void add_ev(input int e, input logic [2:0] r, input logic y);
      ev_t ev;
      ev.edge_no = e;
      ev.rst_v   = r;
      ev.rdy     = y;
      ev.cause   = m_cause;
      ev.fault   = m_fault;
      plan.push_back(ev);
   endfunction

   // Stage k released at edge t advances at the first edge >= t+SG where its
   // ready is seen high, unless that lies beyond t+RT (timeout at t+RT).
   task automatic model_seq(input int t0, output int erun);
      int t, k, adv;
      t    = t0;
      k    = 0;
      erun = -1;
      add_ev(t, 3'b110, 1'b0);
      for (int guard = 0; guard < 64 && erun < 0; guard++) begin
         adv = (t + SG > rdy_at[k]) ? t + SG : rdy_at[k];
         if (adv <= t + RT) begin
            if (k == NS - 1) begin
               erun = adv;
               add_ev(adv, 3'b000, 1'b1);
            end else begin
               k++;
               t = adv;
               add_ev(t, 3'b111 << (k + 1), 1'b0);
            end
         end else begin
            m_cause = CAUSE_TIMEOUT;
            m_fault = 3'(k);
            add_ev(t + RT, 3'b111, 1'b0);
            t = t + RT + M;
            k = 0;
            add_ev(t, 3'b110, 1'b0);
         end
      end
      if (erun < 0) erun = t;
   endtask

   logic [8:0] prev_v;
   logic [8:0] cur_v;
   logic [8:0] exp_v;
   ev_t        got_ev;

   always begin
      @(posedge sys_clk);
      #1;
      if (rst_sig) begin
         prev_v = {3'b111, 1'b0, 2'b00, 3'b000};
      end else begin
         cur_v = {stage_rst, sys_ready, rst_cause, fault_stage};
         checks++;
         for (int j = 0; j < NS - 1; j++) begin
            if (stage_rst[j] && !stage_rst[j+1]) begin
               errors++;
               $display("FAIL thermometer edge %0d: stage_rst=%b", cyc, stage_rst);
            end
         end
         if (sys_ready && stage_rst != '0) begin
            errors++;
            $display("FAIL ready_vs_rst edge %0d: stage_rst=%b with sys_ready=1, required 000", cyc, stage_rst);
         end
         if (cur_v != prev_v) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change edge %0d: got %b, required no change from %b", cyc, cur_v, prev_v);
            end else begin
               got_ev = exp_q.pop_front();
               exp_v  = {got_ev.rst_v, got_ev.rdy, got_ev.cause, got_ev.fault};
               if (got_ev.edge_no != cyc || cur_v != exp_v) begin
                  errors++;
                  $display("FAIL event: got rst/rdy/cause/fault=%b at edge %0d, required %b at edge %0d",
                           cur_v, cyc, exp_v, got_ev.edge_no);
               end
            end
            prev_v = cur_v;
         end
      end
   end

   // kind: 0 ready tied high, 1 stage1 ready 40 cycles late, 2 stage2 times out, 3 random
   // ending: 0 soft reset in RUN (plus one in HOLD), 1 ready drop in RUN, 2 abort by rst_sig
   task automatic run_scenario(input int kind, input int ending);
      int base, erun, erun2, end_e, low;
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
      end
      exp_q.delete();
      rst_sig    = 1'b1;
      sw_rst_req = 1'b0;
      #1;
      checks++;
      if ({stage_rst, sys_ready, rst_cause, fault_stage} != {3'b111, 1'b0, 2'b00, 3'b000}) begin
         errors++;
         $display("FAIL async_reset: got %b, required 111_0_00_000",
                  {stage_rst, sys_ready, rst_cause, fault_stage});
      end
      repeat (2) @(posedge sys_clk);
      #2;
      rst_sig = 1'b0;
      base    = cyc;
      m_cause = CAUSE_EXT;
      m_fault = 3'b000;
      plan.delete();
      sw_a      = -1;
      sw_b      = -1;
      drop_at   = -1;
      drop_mask = '0;
      for (int k = 0; k < NS; k++) begin
         rdy_at[k] = (kind == 3) ? base + int'($urandom_range(0, 450)) : 0;
      end
      if (kind == 1) rdy_at[1] = base + M + SG + 40;
      if (kind == 2) rdy_at[2] = base + M + 2 * SG + 300;
      model_seq(base + M, erun);
      case (ending)
         0: begin
            sw_a    = erun + int'($urandom_range(1, 20));
            m_cause = CAUSE_SOFT;
            add_ev(sw_a, 3'b111, 1'b0);
            sw_b = sw_a + int'($urandom_range(1, M - 1));
            model_seq(sw_a + M, erun2);
            end_e = erun2 + 5;
         end
         1: begin
            drop_at   = erun + int'($urandom_range(1, 20));
            drop_mask = NS'($urandom_range(1, (1 << NS) - 1));
            if ($urandom_range(0, 1) == 1) begin
               sw_a    = drop_at;
               m_cause = CAUSE_SOFT;
            end else begin
               low = 0;
               for (int k = NS - 1; k >= 0; k--) if (drop_mask[k]) low = k;
               m_cause = CAUSE_TIMEOUT;
               m_fault = 3'(low);
            end
            add_ev(drop_at, 3'b111, 1'b0);
            end_e = drop_at + 5;
         end
         default: begin
            end_e = base + M + int'($urandom_range(0, erun - base - M - 1));
         end
      endcase
      foreach (plan[i]) begin
         if (plan[i].edge_no <= end_e) exp_q.push_back(plan[i]);
      end
      while (cyc < end_e) begin
         for (int k = 0; k < NS; k++) begin
            stage_ready[k] = (cyc + 1 >= rdy_at[k]) &&
                             !(drop_at >= 0 && cyc + 1 >= drop_at && drop_mask[k]);
         end
         sw_rst_req = (cyc + 1 == sw_a) || (cyc + 1 == sw_b);
         @(posedge sys_clk);
         #1;
      end
   endtask

   initial begin
      rst_sig = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      run_scenario(0, 0);
      run_scenario(1, 1);
      run_scenario(2, 0);
      run_scenario(0, 2);
      for (int i = 0; i < 8; i++) begin
         run_scenario(3, int'($urandom_range(0, 2)));
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_drain: got %0d outstanding events, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of staged reset outputs, legal 1..8.
REQ-002 Parameter MIN_ASSERT, default 32: minimum cycles all stages are held in reset before any release, legal 1..65535.
REQ-003 Parameter STAGE_GAP, default 16: minimum cycles between releasing stage k and stage k+1, legal 1..65535.
REQ-004 Parameter READY_TIMEOUT, default 256: cycles allowed for stage_ready[k] after stage k is released, legal > STAGE_GAP.
REQ-005 sys_clk  input  1  system clock (12 MHz); all logic on rising edge.
REQ-006 rst_sig  input  1  asynchronous, active-high reset from the debounced reset pin.
REQ-007 sw_rst_req  input  1  synchronous single-cycle soft-reset request.
REQ-008 stage_ready  input  NUM_STAGES  per-stage "initialised" status, synchronous to sys_clk.
REQ-009 stage_rst  output  NUM_STAGES  active-high reset to each downstream stage; bit 0 is released first.
REQ-010 sys_ready  output  1  high only when every stage is released and ready.
REQ-011 rst_cause  output  2  last reset cause: 0 external, 1 soft, 2 timeout, 3 reserved (never driven).
REQ-012 fault_stage  output  3  index of the stage that last timed out; valid when rst_cause==2.

Function
REQ-013 FSM states SHALL be HOLD, RELEASE, RUN; no other reachable state.
REQ-014 HOLD: all stage_rst=1, sys_ready=0; hold counter increments each cycle; on the edge where counter reaches MIN_ASSERT-1, go to RELEASE with k=0 and clear stage_rst[0] on that same edge.
REQ-015 Consequently stage_rst[0] SHALL fall exactly MIN_ASSERT rising edges after the first edge at which rst_sig is sampled low.
REQ-016 RELEASE(k): gap counter restarts at 0 on the edge that releases stage k; advance when gap counter >= STAGE_GAP-1 AND stage_ready[k]==1.
REQ-017 Advance with k<NUM_STAGES-1: clear stage_rst[k+1], k=k+1; with k==NUM_STAGES-1: go to RUN, sys_ready=1 on the same edge.
REQ-018 Timeout: if stage_ready[k] is still 0 when gap counter reaches READY_TIMEOUT-1, set all stage_rst=1, rst_cause=2, fault_stage=k, return to HOLD (hold counter cleared); retries are unlimited.
REQ-019 Released stages SHALL stay released while later stages sequence; stage_ready of already-released stages is ignored outside RUN.
REQ-020 RUN: if any stage_ready bit falls, treat it as a timeout of the lowest such stage (same action as REQ-018).
REQ-021 sw_rst_req in RELEASE or RUN: all stage_rst=1, sys_ready=0, rst_cause=1, go to HOLD on the next edge; sw_rst_req in HOLD is ignored and does not restart the count.
REQ-022 Simultaneous sw_rst_req and timeout/ready-drop on the same edge: soft reset wins (rst_cause=1).
REQ-023 Counters SHALL saturate, never wrap; widths SHALL be sized from the largest parameter.
REQ-024 stage_rst SHALL be thermometer-shaped at all times: stage_rst[j]=1 implies stage_rst[j+1]=1.

Reset
REQ-025 rst_sig high SHALL asynchronously force HOLD, stage_rst all 1, sys_ready=0, counters 0, k=0, rst_cause=0, fault_stage=0.
REQ-026 Release of rst_sig is synchronous; rst_sig reasserted mid-RELEASE or in RUN SHALL reassert every stage_rst immediately, without waiting for a clock edge.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the rst_cause codes (CAUSE_EXT, CAUSE_SOFT, CAUSE_TIMEOUT).
REQ-028 One sub-module, sequencer_timer (clear/enable, saturating up-counter with terminal-compare output), SHALL be instantiated for both the hold and gap counters.

Verification (MIN_ASSERT=32, STAGE_GAP=16, READY_TIMEOUT=256, NUM_STAGES=3)
REQ-029 rst_sig pulsed then low, stage_ready tied 1 -> stage_rst 111→110 at edge 32, →100 at edge 48, →000 and sys_ready=1 at edge 64, rst_cause=0.
REQ-030 stage_ready[1] raised 40 cycles after stage 1 release -> stage 2 released on that same edge; no earlier.
REQ-031 stage_ready[2] held 0 -> at 256 cycles after stage 2 release, stage_rst=111, rst_cause=2, fault_stage=2; release sequence restarts.
REQ-032 sw_rst_req in RUN -> stage_rst=111 and sys_ready=0 next edge, rst_cause=1, full sequence repeats; sw_rst_req during HOLD -> timing unchanged.
REQ-033 rst_sig asserted between clock edges mid-RELEASE -> stage_rst=111 before the next edge; rst_cause=0.
REQ-034 Assertion over all tests: stage_rst always thermometer-shaped; sys_ready implies stage_rst==000.
